// File: rtl/fetch_queue_if.sv
// Fetch/decode handshake bundle for fetch_queue: push side from fetch, two-slot read side to decode.
interface fetch_queue_if #(
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic          flush_i;
  logic          push_valid_i;
  logic [31:0]   InstrF;
  logic [31:0]   PCF;
  logic [31:0]   PCPlus4F;
  logic          push_ready_o;
  logic [1:0]    pop_count_i;
  logic          valid0_o;
  logic [31:0]   Instr0D;
  logic [31:0]   PC0D;
  logic [31:0]   PCPlus40D;
  logic          valid1_o;
  logic [31:0]   Instr1D;
  logic [31:0]   PC1D;
  logic [31:0]   PCPlus41D;
  logic [AW:0]   count_o;
  logic          pop_err_o;

  modport master (
    output flush_i, push_valid_i, InstrF, PCF, PCPlus4F, pop_count_i,
    input  push_ready_o, valid0_o, Instr0D, PC0D, PCPlus40D,
    input  valid1_o, Instr1D, PC1D, PCPlus41D, count_o, pop_err_o
  );

  modport slave (
    input  flush_i, push_valid_i, InstrF, PCF, PCPlus4F, pop_count_i,
    output push_ready_o, valid0_o, Instr0D, PC0D, PCPlus40D,
    output valid1_o, Instr1D, PC1D, PCPlus41D, count_o, pop_err_o
  );
endinterface

// File: rtl/fetch_queue.sv
// Circular instruction queue feeding dual-issue decode; up to 1 push and 2 pops per cycle.
// Optional same-cycle empty-queue bypass to slot 0 under FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
  parameter int unsigned DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.slave  fq
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [95:0]   mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_ptr_p1;
  logic [AW:0]   count_q, count_d;
  logic          pop_err_q;

  logic [1:0]    pop_req, stored_avail, stored_pop;
  logic          stored_v0, stored_v1;
  logic          bypass, byp_take, over_pop;
  logic          push_ready, push_acc, wr_en;
  logic          v0, v1;
  logic [95:0]   push_bundle, slot0, slot1;

  always_comb begin
    push_bundle  = {fq.InstrF, fq.PCF, fq.PCPlus4F};
    pop_req      = (fq.pop_count_i == 2'd3) ? 2'd2 : fq.pop_count_i;
    stored_v0    = (count_q != '0);
    stored_v1    = (count_q >= (AW+1)'(2));
    stored_avail = {1'b0, stored_v0} + {1'b0, stored_v1};
    stored_pop   = (pop_req < stored_avail) ? pop_req : stored_avail;
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass       = (count_q == '0) && fq.push_valid_i && rst && !fq.flush_i;
`else
    bypass       = 1'b0;
`endif
    // A bypassed bundle that decode takes this cycle never lands in the array.
    byp_take     = bypass && (pop_req != 2'd0);
    over_pop     = pop_req > (stored_avail + {1'b0, bypass});

    push_ready   = rst && (count_q < (AW+1)'(DEPTH));
    push_acc     = fq.push_valid_i && push_ready && !fq.flush_i;
    wr_en        = push_acc && !byp_take;

    count_d      = count_q + (AW+1)'(wr_en) - (AW+1)'(stored_pop);
    rd_ptr_d     = rd_ptr_q + AW'(stored_pop);
    wr_ptr_d     = wr_ptr_q + AW'(wr_en);
    rd_ptr_p1    = rd_ptr_q + AW'(1);

    v0           = rst && (stored_v0 || bypass);
    v1           = rst && stored_v1;
    slot0        = '0;
    slot1        = '0;
    if (v0) slot0 = bypass ? push_bundle : mem_q[rd_ptr_q];
    if (v1) slot1 = mem_q[rd_ptr_p1];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      pop_err_q <= 1'b0;
    end else if (fq.flush_i) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      pop_err_q <= 1'b0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      if (over_pop) pop_err_q <= 1'b1;
    end
  end

  // Storage carries no reset; wr_en already excludes reset and flush cycles.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_bundle;
  end

  assign fq.push_ready_o = push_ready;
  assign fq.valid0_o     = v0;
  assign fq.valid1_o     = v1;
  assign fq.Instr0D      = slot0[95:64];
  assign fq.PC0D         = slot0[63:32];
  assign fq.PCPlus40D    = slot0[31:0];
  assign fq.Instr1D      = slot1[95:64];
  assign fq.PC1D         = slot1[63:32];
  assign fq.PCPlus41D    = slot1[31:0];
  assign fq.count_o      = count_q;
  assign fq.pop_err_o    = pop_err_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus random traffic against a queue model.
module tb_fetch_queue;
  localparam int unsigned DEPTH = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_queue_if #(.DEPTH(DEPTH)) fq ();

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .fq  (fq)
  );

  logic [95:0] model_q [$];
  logic        model_err;
  logic [31:0] next_pc;
  int          n_vec;
  int          n_miscmp;

  task automatic check_val(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle, check outputs mid-cycle against the model, then advance the model.
  task automatic step(input logic r, input logic fl, input logic pv, input logic [1:0] pc);
    logic [95:0] b, s0, s1;
    logic        byp, ev0, ev1, ready;
    int          sz, req, avail, n;
    b = {$urandom, next_pc, next_pc + 32'd4};
    rst             = r;
    fq.flush_i      = fl;
    fq.push_valid_i = pv;
    fq.InstrF       = b[95:64];
    fq.PCF          = b[63:32];
    fq.PCPlus4F     = b[31:0];
    fq.pop_count_i  = pc;
    @(negedge clk);
    sz    = model_q.size();
    byp   = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    byp   = (sz == 0) && pv && r && !fl;
`endif
    ready = r && (sz < DEPTH);
    ev0   = r && (sz >= 1 || byp);
    ev1   = r && (sz >= 2);
    s0    = '0;
    s1    = '0;
    if (ev0) s0 = byp ? b : model_q[0];
    if (ev1) s1 = model_q[1];
    check_val("push_ready", 96'(fq.push_ready_o), 96'(ready));
    check_val("count", 96'(fq.count_o), 96'(sz));
    check_val("pop_err", 96'(fq.pop_err_o), 96'(model_err));
    check_val("valid0", 96'(fq.valid0_o), 96'(ev0));
    check_val("valid1", 96'(fq.valid1_o), 96'(ev1));
    check_val("slot0", {fq.Instr0D, fq.PC0D, fq.PCPlus40D}, s0);
    check_val("slot1", {fq.Instr1D, fq.PC1D, fq.PCPlus41D}, s1);

    if (!r || fl) begin
      model_q.delete();
      model_err = 1'b0;
    end else begin
      req = (pc == 2'd3) ? 2 : int'(pc);
      if (byp && req >= 1) begin
        if (req > 1) model_err = 1'b1;
      end else begin
        avail = (sz < 2) ? sz : 2;
        if (req > avail + (byp ? 1 : 0)) model_err = 1'b1;
        n = (req < avail) ? req : avail;
        for (int i = 0; i < n; i++) void'(model_q.pop_front());
        if (pv && sz < DEPTH) model_q.push_back(b);
      end
      if (pv && sz < DEPTH) next_pc = next_pc + 32'd4;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec           = 0;
    n_miscmp        = 0;
    model_err       = 1'b0;
    next_pc         = 32'h0;
    rst             = 1'b0;
    fq.flush_i      = 1'b0;
    fq.push_valid_i = 1'b1;
    fq.InstrF       = '0;
    fq.PCF          = '0;
    fq.PCPlus4F     = '0;
    fq.pop_count_i  = 2'd0;
    @(posedge clk);
    #1;

    // Reset held with pushes offered
    step(1'b0, 1'b0, 1'b1, 2'd0);
    step(1'b0, 1'b0, 1'b1, 2'd0);
    next_pc = 32'h0;

    // Three pushes then observe both slots
    repeat (3) step(1'b1, 1'b0, 1'b1, 2'd0);
    step(1'b1, 1'b0, 1'b0, 2'd0);

    // Fill to full, pop 2 while full (push rejected), then push accepted
    repeat (6) step(1'b1, 1'b0, 1'b1, 2'd0);
    step(1'b1, 1'b0, 1'b1, 2'd2);
    step(1'b1, 1'b0, 1'b1, 2'd0);
    repeat (5) step(1'b1, 1'b0, 1'b0, 2'd2);

    // Wrap: 10 pushes popping one per cycle, then drain
    step(1'b1, 1'b1, 1'b0, 2'd0);
    next_pc = 32'h0;
    repeat (10) step(1'b1, 1'b0, 1'b1, 2'd1);
    repeat (3) step(1'b1, 1'b0, 1'b0, 2'd1);

    // Over-pop sets sticky error; flush clears it and drops the push
    step(1'b1, 1'b0, 1'b1, 2'd0);
    step(1'b1, 1'b0, 1'b0, 2'd2);
    step(1'b1, 1'b0, 1'b0, 2'd0);
    step(1'b1, 1'b1, 1'b1, 2'd0);
    step(1'b1, 1'b0, 1'b0, 2'd0);

    // Empty-queue push with simultaneous pop
    next_pc = 32'h40;
    step(1'b1, 1'b0, 1'b1, 2'd1);
    step(1'b1, 1'b0, 1'b0, 2'd0);

    // Random traffic with occasional flush and reset
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 63) != 0),
           ($urandom_range(0, 31) == 0),
           ($urandom_range(0, 3) != 0),
           2'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end
endmodule
